// File: rtl/dmem_responder.sv
// Big-endian byte-addressed data memory for the pipelined MIPS core.
// Serves sized reads and writes, zeroes itself after reset, and latches access faults.
module dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32,
    parameter int CLR_WORDS = MEM_BYTES / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] RAddr_d,
    input  logic [1:0]        RSize,
    output logic [31:0]       Rdata_d,
    input  logic              Wen,
    input  logic [1:0]        WSize,
    input  logic [ADDR_W-1:0] WAddr_d,
    input  logic [31:0]       Wdata_d,
    output logic              ready,
    output logic              err_misalign,
    output logic              err_overflow,
    output logic              halt,
    output logic [15:0]       wr_count
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int PTR_W = (CLR_WORDS > 1) ? $clog2(CLR_WORDS) : 1;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PTR_W-1:0] r_ptr;
    logic [7:0]       r_mem [MEM_BYTES];
    logic             r_err_mis;
    logic             r_err_ovf;
    logic [15:0]      r_wr_count;

    logic             w_ready;
    logic             w_clearing;
    logic [IDX_W-1:0] w_clr_base;
    logic [IDX_W-1:0] w_ridx [4];
    logic [IDX_W-1:0] w_widx [4];
    logic [7:0]       w_rb [4];
    logic [7:0]       w_wbyte [4];
    logic [3:0]       w_wen;
    logic             w_rd_act, w_rd_mis, w_rd_ovf, w_rd_ok;
    logic             w_wr_act, w_wr_mis, w_wr_ovf, w_wr_commit;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b11:   return 3'd4;
            2'b10:   return 3'd2;
            2'b01:   return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lsb);
        return ((sz == 2'b11) && (lsb != 2'b00)) || ((sz == 2'b10) && lsb[0]);
    endfunction

    // The end address is formed one bit wider so addresses near 2^ADDR_W cannot wrap into range.
    function automatic logic overflow(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        logic [ADDR_W:0] last_excl;
        last_excl = {1'b0, a} + (ADDR_W+1)'(size_bytes(sz));
        return last_excl > (ADDR_W+1)'(MEM_BYTES);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            if (w_clearing)
                r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        if (r_state == S_CLEAR && r_ptr == PTR_W'(CLR_WORDS - 1))
            w_next = S_READY;
    end

    // Output decode.
    always_comb begin
        w_ready    = (r_state == S_READY);
        w_clearing = (r_state == S_CLEAR);
    end

    assign w_rd_act    = w_ready && (RSize != 2'b00);
    assign w_rd_mis    = w_rd_act && misaligned(RSize, RAddr_d[1:0]);
    assign w_rd_ovf    = w_rd_act && overflow(RAddr_d, RSize);
    assign w_rd_ok     = w_rd_act && !w_rd_mis && !w_rd_ovf;
    assign w_wr_act    = w_ready && Wen && (WSize != 2'b00);
    assign w_wr_mis    = w_wr_act && misaligned(WSize, WAddr_d[1:0]);
    assign w_wr_ovf    = w_wr_act && overflow(WAddr_d, WSize);
    assign w_wr_commit = w_wr_act && !w_wr_mis && !w_wr_ovf;
    assign w_clr_base  = IDX_W'({r_ptr, 2'b00});

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_ridx[k] = RAddr_d[IDX_W-1:0] + IDX_W'(k);
            w_widx[k] = WAddr_d[IDX_W-1:0] + IDX_W'(k);
            w_rb[k]   = r_mem[w_ridx[k]];
        end
    end

    // Big-endian lane mapping: the most significant written byte lands at the lowest address.
    always_comb begin
        w_wen = 4'b0000;
        for (int k = 0; k < 4; k++)
            w_wbyte[k] = 8'h00;
        case (WSize)
            2'b11: begin
                w_wen      = 4'b1111;
                w_wbyte[0] = Wdata_d[31:24];
                w_wbyte[1] = Wdata_d[23:16];
                w_wbyte[2] = Wdata_d[15:8];
                w_wbyte[3] = Wdata_d[7:0];
            end
            2'b10: begin
                w_wen      = 4'b0011;
                w_wbyte[0] = Wdata_d[15:8];
                w_wbyte[1] = Wdata_d[7:0];
            end
            2'b01: begin
                w_wen      = 4'b0001;
                w_wbyte[0] = Wdata_d[7:0];
            end
            default: w_wen = 4'b0000;
        endcase
    end

    // NOTE: the array has no reset branch; it is cleared by the sweep so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_clearing) begin
            for (int k = 0; k < 4; k++)
                r_mem[w_clr_base + IDX_W'(k)] <= 8'h00;
        end else if (w_wr_commit) begin
            for (int k = 0; k < 4; k++)
                if (w_wen[k])
                    r_mem[w_widx[k]] <= w_wbyte[k];
        end
    end

    always_comb begin
        Rdata_d = 32'h0;
        if (w_rd_ok) begin
            case (RSize)
                2'b11:   Rdata_d = {w_rb[0], w_rb[1], w_rb[2], w_rb[3]};
                2'b10:   Rdata_d = {16'h0, w_rb[0], w_rb[1]};
                2'b01:   Rdata_d = {24'h0, w_rb[0]};
                default: Rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_mis  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_wr_count <= 16'h0;
        end else begin
            if (w_rd_mis || w_wr_mis)
                r_err_mis <= 1'b1;
            if (w_rd_ovf || w_wr_ovf)
                r_err_ovf <= 1'b1;
            if (w_wr_commit && r_wr_count != 16'hFFFF)
                r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign ready        = w_ready;
    assign err_misalign = r_err_mis;
    assign err_overflow = r_err_ovf;
    assign halt         = r_err_mis | r_err_ovf;
    assign wr_count     = r_wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder: reset sweep, sized big-endian
// access, fault flags, mid-sweep reset and write-counter saturation.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] RAddr_d = '0;
    logic [1:0]  RSize = '0;
    logic [31:0] Rdata_d;
    logic        Wen = 1'b0;
    logic [1:0]  WSize = '0;
    logic [31:0] WAddr_d = '0;
    logic [31:0] Wdata_d = '0;
    logic        ready, err_misalign, err_overflow, halt;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] SZ_N = 2'b00, SZ_B = 2'b01, SZ_H = 2'b10, SZ_W = 2'b11;

    dmem_responder #(.MEM_BYTES(1024), .ADDR_W(32), .CLR_WORDS(256)) dut (
        .clk(clk), .rst(rst),
        .RAddr_d(RAddr_d), .RSize(RSize), .Rdata_d(Rdata_d),
        .Wen(Wen), .WSize(WSize), .WAddr_d(WAddr_d), .Wdata_d(Wdata_d),
        .ready(ready), .err_misalign(err_misalign), .err_overflow(err_overflow),
        .halt(halt), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // rst_mode: 0 none, 1 reset + quiet sweep, 2 reset + sweep with illegal traffic, 3 as 2 plus abort at cycle 100
    typedef struct {
        int          rst_mode;
        logic        wen;
        logic [1:0]  wsize;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  rsize;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_ovf;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input int m, input logic we, input logic [1:0] ws, input logic [31:0] wa,
                                input logic [31:0] wd, input logic [1:0] rs, input logic [31:0] ra,
                                input logic [31:0] er, input logic em, input logic eo, input logic [15:0] ec);
        vec_t v;
        v.rst_mode = m;  v.wen = we;   v.wsize = ws;  v.waddr = wa;  v.wdata = wd;
        v.rsize = rs;    v.raddr = ra; v.exp_rdata = er;
        v.exp_mis = em;  v.exp_ovf = eo; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reset_sweep(input int mode);
        int cyc;
        bit rd_nonzero;
        @(negedge clk);
        rst     = 1'b1;
        Wen     = (mode >= 2);
        WSize   = SZ_W;
        WAddr_d = 32'd0;
        Wdata_d = 32'hFFFF_FFFF;
        RSize   = SZ_W;
        RAddr_d = (mode >= 2) ? 32'd6 : 32'd0;
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_flags", {29'b0, halt, err_overflow, err_misalign}, 32'd0);
        check("rst_cnt", {16'b0, wr_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        if (mode == 3) begin
            repeat (100) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("abort_ready", {31'b0, ready}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
        end
        cyc = 0;
        rd_nonzero = 1'b0;
        while (!ready && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!ready && Rdata_d !== 32'h0)
                rd_nonzero = 1'b1;
        end
        check("sweep_len", cyc, 32'd256);
        check("sweep_rdata_zero", {31'b0, rd_nonzero}, 32'd0);
        check("sweep_ready", {31'b0, ready}, 32'd1);
        check("sweep_flags", {29'b0, halt, err_overflow, err_misalign}, 32'd0);
        check("sweep_cnt", {16'b0, wr_count}, 32'd0);
        @(negedge clk);
        Wen   = 1'b0;
        RSize = SZ_N;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        Wen = v.wen;  WSize = v.wsize;  WAddr_d = v.waddr;  Wdata_d = v.wdata;
        RSize = v.rsize;  RAddr_d = v.raddr;
        #1;
        check($sformatf("v%0d_rdata", idx), Rdata_d, v.exp_rdata);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_misalign", idx), {31'b0, err_misalign}, {31'b0, v.exp_mis});
        check($sformatf("v%0d_overflow", idx), {31'b0, err_overflow}, {31'b0, v.exp_ovf});
        check($sformatf("v%0d_halt", idx), {31'b0, halt}, {31'b0, v.exp_mis | v.exp_ovf});
        check($sformatf("v%0d_wr_count", idx), {16'b0, wr_count}, {16'b0, v.exp_cnt});
    endtask

    initial begin
        //                 m  we ws    waddr         wdata          rs    raddr          rdata         mis ovf cnt
        vecs[0]  = mk(1, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd1020,      32'h0,         0, 0, 16'd0);
        vecs[1]  = mk(0, 1, SZ_W, 32'd8,        32'h11223344,  SZ_N, 32'd0,         32'h0,         0, 0, 16'd1);
        vecs[2]  = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_B, 32'd9,         32'h00000022,  0, 0, 16'd1);
        vecs[3]  = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_H, 32'd10,        32'h00003344,  0, 0, 16'd1);
        vecs[4]  = mk(0, 1, SZ_B, 32'd11,       32'hFFFFFFAB,  SZ_W, 32'd8,         32'h11223344,  0, 0, 16'd2);
        vecs[5]  = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd8,         32'h112233AB,  0, 0, 16'd2);
        vecs[6]  = mk(0, 1, SZ_H, 32'd8,        32'h1234BEEF,  SZ_W, 32'd8,         32'h112233AB,  0, 0, 16'd3);
        vecs[7]  = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd8,         32'hBEEF33AB,  0, 0, 16'd3);
        vecs[8]  = mk(0, 1, SZ_N, 32'd0,        32'hFFFFFFFF,  SZ_W, 32'd0,         32'h0,         0, 0, 16'd3);
        vecs[9]  = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd0,         32'h0,         0, 0, 16'd3);
        vecs[10] = mk(0, 1, SZ_W, 32'd4,        32'hCAFEF00D,  SZ_W, 32'd4,         32'h0,         0, 0, 16'd4);
        vecs[11] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd4,         32'hCAFEF00D,  0, 0, 16'd4);
        vecs[12] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_H, 32'd6,         32'h0000F00D,  0, 0, 16'd4);
        vecs[13] = mk(0, 1, SZ_W, 32'd1020,     32'hDEADBEEF,  SZ_B, 32'd1023,      32'h0,         0, 0, 16'd5);
        vecs[14] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_B, 32'd1023,      32'h000000EF,  0, 0, 16'd5);
        vecs[15] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd1020,      32'hDEADBEEF,  0, 0, 16'd5);
        vecs[16] = mk(0, 1, SZ_W, 32'd6,        32'h55555555,  SZ_W, 32'd8,         32'hBEEF33AB,  1, 0, 16'd5);
        vecs[17] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd4,         32'hCAFEF00D,  1, 0, 16'd5);
        vecs[18] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd8,         32'hBEEF33AB,  1, 0, 16'd5);
        vecs[19] = mk(1, 1, SZ_B, 32'd1024,     32'h00000077,  SZ_N, 32'd0,         32'h0,         0, 1, 16'd0);
        vecs[20] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_B, 32'd0,         32'h0,         0, 1, 16'd0);
        vecs[21] = mk(1, 1, SZ_W, 32'd1020,     32'h01020304,  SZ_N, 32'd0,         32'h0,         0, 0, 16'd1);
        vecs[22] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'hFFFFFFFC,  32'h0,         0, 1, 16'd1);
        vecs[23] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd1020,      32'h01020304,  0, 1, 16'd1);
        vecs[24] = mk(2, 0, SZ_N, 32'd0,        32'h0,         SZ_W, 32'd0,         32'h0,         0, 0, 16'd0);
        vecs[25] = mk(0, 0, SZ_N, 32'd0,        32'h0,         SZ_H, 32'd1023,      32'h0,         1, 1, 16'd0);
        vecs[26] = mk(3, 0, SZ_N, 32'd0,        32'h0,         SZ_B, 32'd1023,      32'h0,         0, 0, 16'd0);
        vecs[27] = mk(0, 1, SZ_H, 32'd1,        32'h0000ABCD,  SZ_W, 32'd1024,      32'h0,         1, 1, 16'd0);

        for (int i = 0; i < 28; i++) begin
            if (vecs[i].rst_mode != 0)
                reset_sweep(vecs[i].rst_mode);
            apply(vecs[i], i);
        end

        // Write counter saturation: one committed byte write every cycle.
        reset_sweep(1);
        @(negedge clk);
        Wen = 1'b1;  WSize = SZ_B;  WAddr_d = 32'd0;  Wdata_d = 32'h5A;  RSize = SZ_N;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", {16'b0, wr_count}, 32'h0000FFFE);
        @(posedge clk);
        #1;
        check("sat_ffff", {16'b0, wr_count}, 32'h0000FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", {16'b0, wr_count}, 32'h0000FFFF);
        @(negedge clk);
        Wen = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipelined MIPS core; it serves the core's data-side read and write requests.
- Holds MEM_BYTES of big-endian byte-addressed storage.
- Writes are sized and synchronous. Reads are sized, combinational and right-justified.
- After reset, a clear-sweep FSM zeroes the array before the block reports ready.
- Misaligned or out-of-range accesses are suppressed and latched into sticky error flags. The test harness uses these flags to halt simulation.

Parameters:
- MEM_BYTES, 1024, storage size in bytes; multiple of 4, power of two.
- ADDR_W, 32, width of the read and write address ports; the full ALU result is checked.
- CLR_WORDS, MEM_BYTES/4, number of words zeroed by the clear sweep.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- RAddr_d  input  ADDR_W  read byte address.
- RSize  input  2  read size: 11 word, 10 halfword, 01 byte, 00 no read.
- Rdata_d  output  32  read data, right-justified, zero-filled above the access size.
- Wen  input  1  write enable.
- WSize  input  2  write size, same encoding as RSize; 00 with Wen=1 is treated as no write.
- WAddr_d  input  ADDR_W  write byte address.
- Wdata_d  input  32  write data, right-justified: byte uses [7:0], halfword uses [15:0].
- ready  output  1  high once the clear sweep is complete.
- err_misalign  output  1  sticky: a misaligned access was detected.
- err_overflow  output  1  sticky: an access fell beyond MEM_BYTES.
- halt  output  1  err_misalign OR err_overflow.
- wr_count  output  16  number of committed writes, saturating.

Behaviour:
- Reset values: ready=0, err_misalign=0, err_overflow=0, halt=0, wr_count=0, clear pointer=0, FSM=CLEAR.
- The storage array itself is not reset; it is zeroed by the sweep.
- FSM states:
  - CLEAR: each cycle writes word[ptr]=0 and increments ptr. After ptr reaches CLR_WORDS-1, the FSM moves to READY on the next edge, so ready rises exactly CLR_WORDS cycles after reset deasserts.
  - READY: serves requests. The FSM stays here until rst.
- rst asserted mid-sweep or mid-operation: immediately returns to CLEAR with ptr=0. Flags and counter are cleared. Memory contents are undefined until the sweep completes.
- While ready=0: Wen is ignored, Rdata_d=0, no error checks are made, and wr_count is held.
- Byte order is big-endian:
  - word at a is {m[a],m[a+1],m[a+2],m[a+3]};
  - halfword at a is {m[a],m[a+1]};
  - byte at a is m[a].
- Alignment: a word needs a[1:0]=00 and a halfword needs a[0]=0; otherwise the access is misaligned. A byte access is never misaligned.
- Overflow: the access is out of range if a + size_bytes > MEM_BYTES. Compute this in ADDR_W+1 bits so the sum cannot wrap.
- Write path: a write is committed at the rising edge when ready=1, Wen=1, WSize≠00 and there is no fault. Only the addressed bytes change.
- A faulting write commits no bytes and sets the corresponding flag(s) at that edge.
- wr_count increments per committed write and saturates at 16'hFFFF.
- Read path is combinational from RAddr_d, RSize and the array. A faulting read gives Rdata_d=0 and sets the flag(s) at the next edge. RSize=00 gives Rdata_d=0 with no checks.
- Read and write to overlapping bytes in the same cycle: Rdata_d shows the pre-write contents. The new data is visible from the cycle after the edge.
- Simultaneous faults: read and write faults in the same cycle set both flags as applicable. A single access can set both flags.
- Flags are sticky until rst. halt is combinational from the flags.

Test Plan:
- Release rst, hold Wen=0, RSize=11, RAddr_d=0 -> ready=0 for 256 cycles, then 1; Rdata_d=0 throughout; after ready, word at 1020 reads 0.
- Write word 0x11223344 at 8, then read byte at 9 -> 0x00000022; read halfword at 10 -> 0x00003344; wr_count=1.
- Write byte 0xAB at 11 over that word, then read word at 8 -> 0x112233AB; halfword write 0xBEEF at 8, then read word -> 0xBEEF33AB.
- Word write at 6 -> array unchanged, err_misalign=1, halt=1, wr_count unchanged; halfword read at 1023 -> Rdata_d=0, err_misalign=1.
- Byte write at 1024 and word read at 0xFFFFFFFC -> both suppressed, err_overflow=1; flags stay high until rst.
- Same cycle: word write 0xCAFEF00D at 4 and word read at 4 -> Rdata_d shows old value that cycle and 0xCAFEF00D next cycle.
- Assert rst at sweep cycle 100 -> ready=0, sweep restarts, ready rises 256 cycles after release.
